// File: rtl/system_sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM state encoding,
// Avalon word addresses of the sysid slave and default expected values.
package system_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1394124174;

  localparam int STALL_W = 16;

  // True in the states that present a read request on the bus.
  function automatic logic is_req(input state_t s);
    return (s == ID_REQ) || (s == TS_REQ);
  endfunction

  // True while a sequence is in flight (FIN already counts as finished).
  function automatic logic is_busy(input state_t s);
    return (s == ID_REQ) || (s == ID_WAIT) || (s == TS_REQ) || (s == TS_WAIT);
  endfunction

endpackage

// File: rtl/system_sysid_wdog.sv
// Stall watchdog: counts consecutive stalled request cycles and flags the
// cycle in which the count reaches the limit, so the FSM can abandon the
// read in that same cycle and the request stays up for exactly 'limit'
// stalled cycles.
module system_sysid_wdog
  import system_sysid_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               count,
  input  logic [STALL_W-1:0] limit,
  output logic               expired
);

  logic [STALL_W-1:0] stall_cnt;

  // Consecutive stall counter; saturates rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      stall_cnt <= '0;
    end else if (count && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // The current stalled cycle is the limit-th one when limit-1 have already elapsed.
  assign expired = count && (stall_cnt >= (limit - 1'b1));

endmodule

// File: rtl/system_sysid_checker.sv
// System-ID checker: reads address 0 (ID) and address 1 (build timestamp)
// of an Avalon-MM sysid slave, compares both against expected values and
// reports the result with a one-cycle done pulse. Handles slave stalls with
// a watchdog and fixed read latencies of 0..3 cycles.
module system_sysid_checker
  import system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        error_timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  // Last latency-counter value before the data beat is on the bus.
  localparam logic [1:0] LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [STALL_W-1:0] TIMEOUT_LIMIT = STALL_W'(TIMEOUT_CYCLES);

  state_t     state;
  state_t     state_next;
  logic [1:0] lat_cnt;
  logic       accept;
  logic       start_seq;
  logic       capture_id;
  logic       capture_ts;
  logic       timeout_hit;
  logic       wdog_clear;
  logic       wdog_count;
  logic       wdog_expired;

  assign accept = is_req(state) && !avm_waitrequest;

  // Stalls only count while a request is pending; any state change or
  // acceptance starts the next request from a fresh count.
  assign wdog_count = is_req(state) && avm_waitrequest;
  assign wdog_clear = !is_req(state) || (state_next != state);

  system_sysid_wdog u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wdog_clear),
    .count   (wdog_count),
    .limit   (TIMEOUT_LIMIT),
    .expired (wdog_expired)
  );

  // State register; reset abandons any in-flight read immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, capture strobes and bus/status outputs.
  always_comb begin
    state_next  = state;
    start_seq   = 1'b0;
    capture_id  = 1'b0;
    capture_ts  = 1'b0;
    timeout_hit = 1'b0;
    avm_read    = is_req(state);
    avm_address = (state == TS_REQ) ? ADDR_TS : ADDR_ID;
    busy        = is_busy(state);
    done        = (state == FIN);

    case (state)
      IDLE: begin
        if (start) begin
          start_seq  = 1'b1;
          state_next = ID_REQ;
        end
      end
      ID_REQ: begin
        if (accept) begin
          if (READ_LATENCY == 0) begin
            capture_id = 1'b1;
            state_next = TS_REQ;
          end else begin
            state_next = ID_WAIT;
          end
        end else if (wdog_expired) begin
          timeout_hit = 1'b1;
          state_next  = FIN;
        end
      end
      ID_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          capture_id = 1'b1;
          state_next = TS_REQ;
        end
      end
      TS_REQ: begin
        if (accept) begin
          if (READ_LATENCY == 0) begin
            capture_ts = 1'b1;
            state_next = FIN;
          end else begin
            state_next = TS_WAIT;
          end
        end else if (wdog_expired) begin
          timeout_hit = 1'b1;
          state_next  = FIN;
        end
      end
      TS_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          capture_ts = 1'b1;
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latency counter: restarts at acceptance, advances in the WAIT states.
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      lat_cnt <= 2'd0;
    end else if ((state == ID_WAIT) || (state == TS_WAIT)) begin
      lat_cnt <= lat_cnt + 2'd1;
    end
  end

  // Captured values, registered compares and the timeout flag; all cleared
  // when a new sequence is accepted so unread fields read back as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_value      <= '0;
      ts_value      <= '0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
      error_timeout <= 1'b0;
    end else begin
      if (start_seq) begin
        id_value      <= '0;
        ts_value      <= '0;
        id_ok         <= 1'b0;
        ts_ok         <= 1'b0;
        error_timeout <= 1'b0;
      end
      if (capture_id) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (capture_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (timeout_hit) begin
        error_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_system_sysid_checker.sv
// Directed bench for system_sysid_checker. Three instances cover the
// default configuration, READ_LATENCY=2 and TIMEOUT_CYCLES=4.
module tb_system_sysid_checker;

  localparam logic [31:0] TS_DEF = 32'd1394124174;
  localparam logic [31:0] ID_B   = 32'h1234_5678;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // Instance 0: default parameters, combinational zero-latency slave.
  logic        start0, busy0, done0, id_ok0, ts_ok0, err0, addr0, rd0, wr0;
  logic [31:0] idv0, tsv0, rdata0, id_ret0, ts_ret0;
  assign rdata0 = addr0 ? ts_ret0 : id_ret0;

  system_sysid_checker dut0 (
    .clock(clock), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .id_ok(id_ok0), .ts_ok(ts_ok0), .error_timeout(err0),
    .id_value(idv0), .ts_value(tsv0), .avm_address(addr0), .avm_read(rd0),
    .avm_waitrequest(wr0), .avm_readdata(rdata0)
  );

  // Instance 1: READ_LATENCY=2, slave returns data two cycles after acceptance.
  logic        start1, busy1, done1, id_ok1, ts_ok1, err1, addr1, rd1, wr1;
  logic [31:0] idv1, tsv1, rdata1;
  logic        p1_v, p1_a, p2_v, p2_a;
  always @(posedge clock) begin
    p1_v <= rd1 & ~wr1;
    p1_a <= addr1;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign rdata1 = p2_v ? (p2_a ? TS_DEF : ID_B) : JUNK;

  system_sysid_checker #(.EXPECTED_ID(ID_B), .READ_LATENCY(2)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .id_ok(id_ok1), .ts_ok(ts_ok1), .error_timeout(err1),
    .id_value(idv1), .ts_value(tsv1), .avm_address(addr1), .avm_read(rd1),
    .avm_waitrequest(wr1), .avm_readdata(rdata1)
  );

  // Instance 2: TIMEOUT_CYCLES=4, zero-latency slave.
  logic        start2, busy2, done2, id_ok2, ts_ok2, err2, addr2, rd2, wr2;
  logic [31:0] idv2, tsv2, rdata2;
  assign rdata2 = addr2 ? TS_DEF : 32'd0;

  system_sysid_checker #(.TIMEOUT_CYCLES(4)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .id_ok(id_ok2), .ts_ok(ts_ok2), .error_timeout(err2),
    .id_value(idv2), .ts_value(tsv2), .avm_address(addr2), .avm_read(rd2),
    .avm_waitrequest(wr2), .avm_readdata(rdata2)
  );

  int passes = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; that is the new cycle.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    start0  = 1'b0; wr0 = 1'b0; id_ret0 = 32'd0; ts_ret0 = TS_DEF;
    start1  = 1'b0; wr1 = 1'b1;
    start2  = 1'b0; wr2 = 1'b0;
    tick(2);

    // Reset state
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_read", rd0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_flags", {id_ok0, ts_ok0, err0}, 0);
    chk("rst_idv", idv0, 0);
    chk("rst_tsv", tsv0, 0);
    reset = 1'b0;
    tick();

    // Default params, zero stall: done at N+3
    start0 = 1'b1;                       // cycle N
    tick();                              // N+1
    start0 = 1'b0;
    chk("t1_n1_read", rd0, 1);
    chk("t1_n1_addr", addr0, 0);
    chk("t1_n1_busy", busy0, 1);
    tick();                              // N+2
    chk("t1_n2_read", rd0, 1);
    chk("t1_n2_addr", addr0, 1);
    chk("t1_n2_done", done0, 0);
    tick();                              // N+3
    chk("t1_n3_done", done0, 1);
    chk("t1_n3_busy", busy0, 0);
    chk("t1_n3_read", rd0, 0);
    chk("t1_n3_addr", addr0, 0);
    chk("t1_id_ok", id_ok0, 1);
    chk("t1_ts_ok", ts_ok0, 1);
    chk("t1_err", err0, 0);
    chk("t1_tsv", tsv0, TS_DEF);
    tick();                              // N+4
    chk("t1_n4_done", done0, 0);
    chk("t1_n4_id_ok_held", id_ok0, 1);

    // Wrong ID, start held high to test ignore-while-busy and restart
    id_ret0 = 32'h0000_0001;
    start0  = 1'b1;                      // N
    tick();                              // N+1
    chk("t2_n1_addr", addr0, 0);
    tick(2);                             // N+3
    chk("t2_done", done0, 1);
    chk("t2_id_ok", id_ok0, 0);
    chk("t2_ts_ok", ts_ok0, 1);
    chk("t2_idv", idv0, 32'h0000_0001);
    tick();                              // N+4 IDLE
    chk("t2_n4_busy", busy0, 0);
    chk("t2_n4_read", rd0, 0);
    chk("t2_n4_done", done0, 0);
    tick();                              // N+5 restarted
    chk("t2_n5_read", rd0, 1);
    chk("t2_n5_addr", addr0, 0);
    chk("t2_n5_ts_ok_clr", ts_ok0, 0);
    start0  = 1'b0;
    id_ret0 = 32'd0;
    tick(2);                             // N+7
    chk("t2_n7_done", done0, 1);
    tick();

    // READ_LATENCY=2, five stall cycles per read: done at N+17
    start1 = 1'b1;                       // N
    tick();                              // N+1
    start1 = 1'b0;
    chk("t3_n1_read", rd1, 1);
    chk("t3_n1_addr", addr1, 0);
    tick(4);                             // N+5
    chk("t3_n5_read", rd1, 1);
    chk("t3_n5_addr", addr1, 0);
    tick();                              // N+6 accept
    wr1 = 1'b0;
    chk("t3_n6_read", rd1, 1);
    tick();                              // N+7
    wr1 = 1'b1;
    chk("t3_n7_read", rd1, 0);
    chk("t3_n7_busy", busy1, 1);
    tick();                              // N+8
    chk("t3_n8_read", rd1, 0);
    tick();                              // N+9
    chk("t3_n9_read", rd1, 1);
    chk("t3_n9_addr", addr1, 1);
    chk("t3_n9_idv", idv1, ID_B);
    tick(4);                             // N+13
    chk("t3_n13_read", rd1, 1);
    chk("t3_n13_addr", addr1, 1);
    tick();                              // N+14 accept
    wr1 = 1'b0;
    tick();                              // N+15
    wr1 = 1'b1;
    tick();                              // N+16
    chk("t3_n16_done", done1, 0);
    tick();                              // N+17
    chk("t3_n17_done", done1, 1);
    chk("t3_id_ok", id_ok1, 1);
    chk("t3_ts_ok", ts_ok1, 1);
    chk("t3_tsv", tsv1, TS_DEF);
    chk("t3_err", err1, 0);
    tick();

    // TIMEOUT_CYCLES=4, waitrequest stuck on address 1
    start2 = 1'b1;                       // N
    tick();                              // N+1 ID accepted
    start2 = 1'b0;
    chk("t4_n1_addr", addr2, 0);
    tick();                              // N+2
    wr2 = 1'b1;
    chk("t4_n2_read", rd2, 1);
    chk("t4_n2_addr", addr2, 1);
    tick(3);                             // N+5, fourth stall cycle
    chk("t4_n5_read", rd2, 1);
    chk("t4_n5_err", err2, 0);
    tick();                              // N+6
    chk("t4_n6_read", rd2, 0);
    chk("t4_n6_done", done2, 1);
    chk("t4_err", err2, 1);
    chk("t4_id_ok", id_ok2, 1);
    chk("t4_ts_ok", ts_ok2, 0);
    chk("t4_tsv", tsv2, 0);
    tick();                              // N+7
    chk("t4_n7_done", done2, 0);
    chk("t4_n7_read", rd2, 0);
    chk("t4_n7_err_held", err2, 1);
    wr2 = 1'b0;
    tick();

    // Reset during address-1 stall, with start high in the same cycle
    id_ret0 = 32'hA5A5_0001;
    start0  = 1'b1;                      // N
    tick();                              // N+1
    start0  = 1'b0;
    tick();                              // N+2
    wr0 = 1'b1;
    chk("t5_n2_idv", idv0, 32'hA5A5_0001);
    chk("t5_n2_addr", addr0, 1);
    tick();                              // N+3 stalled
    chk("t5_n3_read", rd0, 1);
    reset  = 1'b1;
    start0 = 1'b1;
    tick();                              // N+4
    chk("t5_rst_busy", busy0, 0);
    chk("t5_rst_read", rd0, 0);
    chk("t5_rst_addr", addr0, 0);
    chk("t5_rst_idv", idv0, 0);
    chk("t5_rst_tsv", tsv0, 0);
    chk("t5_rst_flags", {id_ok0, ts_ok0, err0, done0}, 0);
    reset   = 1'b0;
    wr0     = 1'b0;
    id_ret0 = 32'd0;
    tick();                              // N+5
    start0 = 1'b0;
    chk("t5_n5_read", rd0, 1);
    chk("t5_n5_addr", addr0, 0);
    chk("t5_n5_idv", idv0, 0);
    tick();                              // N+6
    chk("t5_n6_addr", addr0, 1);
    tick();                              // N+7
    chk("t5_n7_done", done0, 1);
    chk("t5_id_ok", id_ok0, 1);
    chk("t5_ts_ok", ts_ok0, 1);
    chk("t5_tsv", tsv0, TS_DEF);
    tick(2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
